// File: rtl/seq_alu.sv
// Clocked ALU: one op per Start/Done handshake, registered result and flags.
// Ports: Clk, Reset, Start, OP, InputA, InputB, SetFlags -> Out, Done, Busy, Zero, Carry, Parity.
module seq_alu #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [Ops-1:0] OP,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic           SetFlags,
  output logic [W-1:0]   Out,
  output logic           Done,
  output logic           Busy,
  output logic           Zero,
  output logic           Carry,
  output logic           Parity
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_LSH = Ops'(1);
  localparam logic [Ops-1:0] OP_RSH = Ops'(2);
  localparam logic [Ops-1:0] OP_XOR = Ops'(3);
  localparam logic [Ops-1:0] OP_RXR = Ops'(4);
  localparam logic [Ops-1:0] OP_SUB = Ops'(5);
  localparam logic [Ops-1:0] OP_ORR = Ops'(6);

  logic [1:0]     state;
  logic [Ops-1:0] op_q;
  logic [W-1:0]   work;
  logic [CW-1:0]  cnt;
  logic           setf_q;

  logic [W-1:0]   res;
  logic           cy;
  logic [W:0]     sum;
  logic           is_shift;
  logic           b_big;
  logic [CW-1:0]  nmin;
  logic [W-1:0]   shifted;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    sum = '0;
    case (OP)
      OP_ADD: begin
        sum = {1'b0, InputA} + {1'b0, InputB};
        res = sum[W-1:0];
        cy  = sum[W];
      end
      OP_SUB: begin
        sum = {1'b0, InputA} + {1'b0, ~InputB} + (W+1)'(1);
        res = sum[W-1:0];
        cy  = sum[W];
      end
      OP_LSH:  res = InputA;
      OP_RSH:  res = InputA;
      OP_XOR:  res = InputA ^ InputB;
      OP_ORR:  res = InputA | InputB;
      OP_RXR:  res = {{(W-1){1'b0}}, ^InputA};
      default: res = '0;
    endcase
  end

  // Shift count saturates at W: anything larger clears the word anyway.
  assign is_shift = (OP == OP_LSH) || (OP == OP_RSH);
  assign b_big    = {1'b0, InputB} >= (W+1)'(W);
  assign nmin     = b_big ? CW'(W) : InputB[CW-1:0];
  assign shifted  = (op_q == OP_LSH) ? (work << 1) : (work >> 1);

  assign Done = (state == DONE);
  assign Busy = (state == SHIFT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= '0;
      work   <= '0;
      cnt    <= '0;
      setf_q <= 1'b0;
      Out    <= '0;
      Zero   <= 1'b0;
      Carry  <= 1'b0;
      Parity <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            Out   <= shifted;
            if (setf_q) begin
              Zero   <= (shifted == '0);
              Carry  <= 1'b0;
              Parity <= ^shifted;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new request (back-to-back in DONE).
          if (Start) begin
            op_q   <= OP;
            setf_q <= SetFlags;
            if (is_shift && (nmin != '0)) begin
              state <= SHIFT;
              work  <= InputA;
              cnt   <= nmin;
            end else begin
              state <= DONE;
              Out   <= res;
              if (SetFlags) begin
                Zero   <= (res == '0);
                Carry  <= cy;
                Parity <= ^res;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
